// File: rtl/posit_bcd_converter.sv
// posit_bcd_converter: sequential posit<NBITS,ES> to sign-magnitude BCD converter with valid/ready handshake
module posit_bcd_converter #(
    parameter int NBITS        = 16,
    parameter int ES           = 1,
    parameter int WHOLE_DIGITS = 10,
    parameter int FRAC_DIGITS  = 10
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NBITS-1:0]          in_posit,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      sign,
    output logic [4*WHOLE_DIGITS-1:0] whole_bcd,
    output logic [4*FRAC_DIGITS-1:0]  frac_bcd,
    output logic                      is_zero,
    output logic                      is_nar,
    output logic                      overflow
);
    localparam int MAXSCALE = (NBITS - 2) << ES;
    localparam int WW = MAXSCALE + 1;
    localparam int FW = MAXSCALE + NBITS;
    localparam int BD = (WW * 121 + 399) / 400 + 1;
    localparam int BDI = BD > WHOLE_DIGITS ? BD : WHOLE_DIGITS + 1;
    localparam logic [15:0] WLAST = 16'(WW - 1);
    localparam logic [15:0] FLAST = 16'(FRAC_DIGITS - 1);
    typedef enum logic [2:0] {IDLE, DECODE, WHOLE, FRAC, DONE} state_t;
    state_t state;
    logic [NBITS-1:0] p;
    logic [WW-1:0] wsh;
    logic [FW-1:0] fsh;
    logic [4*BDI-1:0] bcd, bcd_adj;
    logic [4*FRAC_DIGITS-1:0] fdig;
    logic [4*FRAC_DIGITS+3:0] fcat;
    logic [FW+3:0] t;
    logic [15:0] cnt;
    logic z, n, zr, nr;
    logic [NBITS-2:0] body, rem;
    logic [NBITS-1:0] mant;
    logic [WW+FW-1:0] fixed;
    logic stop;
    int run, scale;
    assign zr = p == '0;
    assign nr = p == {1'b1, {(NBITS-1){1'b0}}};
    // Magnitude decode: regime run length, exponent, then 1.m placed at binary point FW.
    always_comb begin
        body = p[NBITS-2:0];
        if (p[NBITS-1]) body = -body;
        run = 0;
        stop = 1'b0;
        for (int i = NBITS - 2; i >= 0; i--) begin
            stop = stop | (body[i] != body[NBITS-2]);
            run = run + (stop ? 0 : 1);
        end
        rem = body << (run + 1);
        scale = ((body[NBITS-2] ? run - 1 : -run) <<< ES) + int'(rem >> (NBITS - 1 - ES));
        mant = {1'b1, rem << ES};
        fixed = {{(WW+FW-NBITS){1'b0}}, mant} << (MAXSCALE + 1 + scale);
    end
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < BDI; i++)
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end
    // frac * 10 as (frac << 3) + (frac << 1); the integer nibble is the next decimal digit
    assign t = {1'b0, fsh, 3'b000} + {3'b000, fsh, 1'b0};
    assign fcat = {fdig, t[FW+3:FW]};
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            in_ready <= 1'b1;
            out_valid <= 1'b0;
            sign <= 1'b0;
            whole_bcd <= '0;
            frac_bcd <= '0;
            is_zero <= 1'b0;
            is_nar <= 1'b0;
            overflow <= 1'b0;
            p <= '0;
            wsh <= '0;
            fsh <= '0;
            bcd <= '0;
            fdig <= '0;
            cnt <= '0;
            z <= 1'b0;
            n <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    p <= in_posit;
                    in_ready <= 1'b0;
                    state <= DECODE;
                end
                DECODE: begin
                    z <= zr;
                    n <= nr;
                    wsh <= (zr | nr) ? '0 : fixed[WW+FW-1:FW];
                    fsh <= (zr | nr) ? '0 : fixed[FW-1:0];
                    bcd <= '0;
                    fdig <= '0;
                    cnt <= '0;
                    state <= WHOLE;
                end
                WHOLE: begin
                    bcd <= {bcd_adj[4*BDI-2:0], wsh[WW-1]};
                    wsh <= wsh << 1;
                    cnt <= cnt == WLAST ? '0 : cnt + 16'd1;
                    if (cnt == WLAST) state <= FRAC;
                end
                FRAC: begin
                    fsh <= t[FW-1:0];
                    fdig <= fcat[4*FRAC_DIGITS-1:0];
                    cnt <= cnt + 16'd1;
                    if (cnt == FLAST) begin
                        state <= DONE;
                        out_valid <= 1'b1;
                        sign <= p[NBITS-1] & ~(z | n);
                        whole_bcd <= bcd[4*WHOLE_DIGITS-1:0];
                        overflow <= |bcd[4*BDI-1:4*WHOLE_DIGITS];
                        frac_bcd <= fcat[4*FRAC_DIGITS-1:0];
                        is_zero <= z;
                        is_nar <= n;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_posit_bcd_converter.sv
// tb_posit_bcd_converter: scoreboard bench for posit16/ES1 to BCD conversion, 10- and 8-digit integer variants
module tb_posit_bcd_converter;
    localparam int ES = 1;
    localparam int FD = 10;
    typedef struct packed {
        logic sign, zero, nar, ovf;
        logic [63:0] whole;
        logic [39:0] frac;
    } exp_t;
    logic clock = 0, reset = 1, in_valid = 0, out_ready = 1, stall = 0;
    logic [15:0] in_posit = 0;
    logic in_ready, out_valid, sign, is_zero, is_nar, overflow;
    logic [39:0] whole_bcd, frac_bcd, frac8;
    logic in_ready8, out_valid8, sign8, zero8, nar8, ovf8;
    logic [31:0] whole8;
    int cyc = 0, checks = 0, errors = 0;
    exp_t q10[$], q8[$];
    int accq[$];
    posit_bcd_converter dut (
        .clock(clock), .reset(reset), .in_posit(in_posit), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .sign(sign), .whole_bcd(whole_bcd),
        .frac_bcd(frac_bcd), .is_zero(is_zero), .is_nar(is_nar), .overflow(overflow));
    posit_bcd_converter #(.WHOLE_DIGITS(8)) dut8 (
        .clock(clock), .reset(reset), .in_posit(in_posit), .in_valid(in_valid), .in_ready(in_ready8),
        .out_valid(out_valid8), .out_ready(out_ready), .sign(sign8), .whole_bcd(whole8),
        .frac_bcd(frac8), .is_zero(zero8), .is_nar(nar8), .overflow(ovf8));
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask
    function automatic bit bitof(input logic [15:0] a, input int i);
        return i >= 0 ? a[i] : 1'b0;
    endfunction
    // Value = mag * 2^(scale - nb); integer part and decimal fraction by plain integer arithmetic
    function automatic exp_t model(input logic [15:0] p, input int wd);
        exp_t r;
        logic [15:0] a;
        longint unsigned mag, whole, rem, den, lim;
        int i, run, k, e, nb, scale, sh;
        r = '0;
        if (p == 16'h0000) begin r.zero = 1; return r; end
        if (p == 16'h8000) begin r.nar = 1; return r; end
        r.sign = p[15];
        a = p[15] ? 16'(-p) : p;
        run = 0;
        i = 14;
        while (i >= 0 && bitof(a, i) == a[14]) begin run++; i--; end
        k = a[14] ? run - 1 : -run;
        i--;
        e = 0;
        for (int j = 0; j < ES; j++) begin e = 2 * e + int'(bitof(a, i)); i--; end
        mag = 1;
        nb = 0;
        while (i >= 0) begin mag = 2 * mag + longint'(bitof(a, i)); nb++; i--; end
        scale = k * (1 << ES) + e;
        if (scale >= nb) begin
            whole = mag << (scale - nb);
            rem = 0;
            den = 1;
        end else begin
            sh = nb - scale;
            whole = mag >> sh;
            den = 64'd1 << sh;
            rem = mag - (whole << sh);
        end
        for (int d = 0; d < FD; d++) begin
            rem = rem * 10;
            r.frac[4*(FD-1-d) +: 4] = 4'(rem / den);
            rem = rem % den;
        end
        lim = 1;
        for (int d = 0; d < wd; d++) lim = lim * 10;
        r.ovf = whole >= lim;
        for (int d = 0; d < wd; d++) begin
            r.whole[4*d +: 4] = 4'(whole % 10);
            whole = whole / 10;
        end
        return r;
    endfunction
    initial begin : mon10
        bit seen;
        exp_t e;
        int a;
        seen = 0;
        forever begin
            @(negedge clock);
            if (!out_valid) seen = 0;
            else if (!seen) begin
                seen = 1;
                if (q10.size() == 0) chk("unexpected_output", 64'(out_valid), 64'd0);
                else begin
                    e = q10.pop_front();
                    a = accq.pop_front();
                    chk("latency", 64'(cyc - a), 64'd40);
                    chk("sign", 64'(sign), 64'(e.sign));
                    chk("whole_bcd", {24'd0, whole_bcd}, {24'd0, e.whole[39:0]});
                    chk("frac_bcd", {24'd0, frac_bcd}, {24'd0, e.frac});
                    chk("flags", {61'd0, is_zero, is_nar, overflow}, {61'd0, e.zero, e.nar, e.ovf});
                end
            end
        end
    end
    initial begin : mon8
        bit seen;
        exp_t e;
        seen = 0;
        forever begin
            @(negedge clock);
            if (!out_valid8) seen = 0;
            else if (!seen) begin
                seen = 1;
                if (q8.size() == 0) chk("unexpected_output8", 64'(out_valid8), 64'd0);
                else begin
                    e = q8.pop_front();
                    chk("whole8", {32'd0, whole8}, {32'd0, e.whole[31:0]});
                    chk("frac8", {24'd0, frac8}, {24'd0, e.frac});
                    chk("flags8", {60'd0, sign8, zero8, nar8, ovf8}, {60'd0, e.sign, e.zero, e.nar, e.ovf});
                end
            end
        end
    end
    initial forever begin
        @(negedge clock);
        if (!stall) out_ready = $urandom_range(0, 3) != 0;
    end
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    task automatic issue(input logic [15:0] v, input bit expect_out);
        int n;
        n = 0;
        @(negedge clock);
        while (!in_ready && n < 300) begin @(negedge clock); n++; end
        if (!in_ready) begin
            chk("in_ready_timeout", 64'(in_ready), 64'd1);
            return;
        end
        in_posit = v;
        in_valid = 1;
        @(posedge clock);
        #1;
        in_valid = 0;
        if (expect_out) begin
            q10.push_back(model(v, 10));
            q8.push_back(model(v, 8));
            accq.push_back(cyc);
        end
    endtask
    task automatic drain();
        int n;
        n = 0;
        while ((q10.size() != 0 || !in_ready) && n < 500) begin @(negedge clock); n++; end
        chk("drain_timeout", 64'(q10.size()), 64'd0);
    endtask
    task automatic check_reset_state(input string name);
        chk({name, "_handshake"}, {60'd0, out_valid, in_ready, out_valid8, in_ready8}, 64'b0101);
        chk({name, "_outputs"}, {7'd0, sign, is_zero, is_nar, overflow, 13'd0, whole_bcd},
            64'd0);
        chk({name, "_frac"}, {24'd0, frac_bcd}, 64'd0);
    endtask
    logic [15:0] dirs[] = '{16'h5922, 16'hd305, 16'h3000, 16'h7fff, 16'h0000, 16'h8000,
                            16'h0001, 16'h8001, 16'hffff, 16'h4000, 16'hc000, 16'h7000};
    initial begin
        logic [39:0] hw, hf;
        logic [3:0] hflags;
        int n;
        #1 reset = 0;
        #20;
        check_reset_state("reset");
        @(negedge clock);
        reset = 1;
        foreach (dirs[i]) issue(dirs[i], 1);
        drain();
        repeat (40) issue(16'($urandom_range(0, 65535)), 1);
        drain();
        // Consumer stall with a second request offered while DONE is held
        stall = 1;
        out_ready = 0;
        issue(16'h5922, 1);
        n = 0;
        while (!out_valid && n < 100) begin @(negedge clock); n++; end
        chk("stall_wait", 64'(out_valid), 64'd1);
        hw = whole_bcd;
        hf = frac_bcd;
        hflags = {sign, is_zero, is_nar, overflow};
        in_posit = 16'h1234;
        in_valid = 1;
        repeat (20) begin
            @(negedge clock);
            chk("stall_hold", {in_ready, out_valid, hflags == {sign, is_zero, is_nar, overflow},
                hw == whole_bcd, hf == frac_bcd}, 64'b01111);
        end
        in_valid = 0;
        out_ready = 1;
        @(negedge clock);
        stall = 0;
        repeat (60) @(negedge clock);
        chk("stall_no_second", 64'(out_valid), 64'd0);
        // Reset pulsed mid-conversion after a completed result left nonzero outputs
        issue(16'h7fff, 1);
        drain();
        issue(16'h5922, 0);
        repeat (15) @(posedge clock);
        #2 reset = 0;
        #1;
        check_reset_state("abort");
        @(negedge clock);
        reset = 1;
        repeat (60) @(negedge clock);
        chk("abort_no_output", 64'(out_valid), 64'd0);
        issue(16'h3000, 1);
        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
